// File: rtl/mem_axil_master.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : mem_axil_master
//  Brief    : Native single-request port to AXI4-Lite master bridge, one
//             outstanding transaction. Optional misaligned-address rejection
//             is enabled by defining MEM_AXIL_ALIGN_CHECK_EN.
//  Revision : 1.0  initial release
// ============================================================================
module mem_axil_master #(
    parameter int WIDTH_P = 32
) (
    input  logic               ACLK,
    input  logic               ARESETN,
    // native request / response
    input  logic               req_valid,
    output logic               req_ready,
    input  logic               req_we,
    input  logic [WIDTH_P-1:0] req_addr,
    input  logic [WIDTH_P-1:0] req_wdata,
    input  logic [3:0]         req_wstrb,
    output logic               rsp_valid,
    input  logic               rsp_ready,
    output logic [WIDTH_P-1:0] rsp_rdata,
    output logic               rsp_err,
    // AXI4-Lite master
    output logic [WIDTH_P-1:0] M_AWADDR,
    output logic               M_AWVALID,
    input  logic               M_AWREADY,
    output logic [WIDTH_P-1:0] M_WDATA,
    output logic [3:0]         M_WSTRB,
    output logic               M_WVALID,
    input  logic               M_WREADY,
    input  logic [1:0]         M_BRESP,
    input  logic               M_BVALID,
    output logic               M_BREADY,
    output logic [WIDTH_P-1:0] M_ARADDR,
    output logic               M_ARVALID,
    input  logic               M_ARREADY,
    input  logic [WIDTH_P-1:0] M_RDATA,
    input  logic [1:0]         M_RRESP,
    input  logic               M_RVALID,
    output logic               M_RREADY
);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_WR_REQ  = 3'd1,
        ST_WR_RESP = 3'd2,
        ST_RD_REQ  = 3'd3,
        ST_RD_RESP = 3'd4,
        ST_RSP     = 3'd5
    } state_t;

    state_t r_state;

    logic w_aw_hs;
    logic w_w_hs;

    assign w_aw_hs = M_AWVALID && M_AWREADY;
    assign w_w_hs  = M_WVALID  && M_WREADY;

    always_ff @(posedge ACLK) begin
        if (!ARESETN) begin
            r_state   <= ST_IDLE;
            req_ready <= 1'b1;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
            M_AWADDR  <= '0;
            M_AWVALID <= 1'b0;
            M_WDATA   <= '0;
            M_WSTRB   <= 4'h0;
            M_WVALID  <= 1'b0;
            M_BREADY  <= 1'b0;
            M_ARADDR  <= '0;
            M_ARVALID <= 1'b0;
            M_RREADY  <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (req_valid && req_ready) begin
                        req_ready <= 1'b0;
                        M_AWADDR  <= req_addr;
                        M_ARADDR  <= req_addr;
                        M_WDATA   <= req_wdata;
                        M_WSTRB   <= req_wstrb;
`ifdef MEM_AXIL_ALIGN_CHECK_EN
                        if (req_addr[1:0] != 2'b00) begin
                            r_state   <= ST_RSP;
                            rsp_valid <= 1'b1;
                            rsp_err   <= 1'b1;
                            rsp_rdata <= '0;
                        end else
`endif
                        if (req_we) begin
                            r_state   <= ST_WR_REQ;
                            M_AWVALID <= 1'b1;
                            M_WVALID  <= 1'b1;
                        end else begin
                            r_state   <= ST_RD_REQ;
                            M_ARVALID <= 1'b1;
                        end
                    end
                end

                // A channel whose VALID is already low has completed its handshake.
                ST_WR_REQ: begin
                    if (w_aw_hs) begin
                        M_AWVALID <= 1'b0;
                    end
                    if (w_w_hs) begin
                        M_WVALID <= 1'b0;
                    end
                    if ((w_aw_hs || !M_AWVALID) && (w_w_hs || !M_WVALID)) begin
                        r_state  <= ST_WR_RESP;
                        M_BREADY <= 1'b1;
                    end
                end

                ST_WR_RESP: begin
                    if (M_BVALID) begin
                        r_state   <= ST_RSP;
                        M_BREADY  <= 1'b0;
                        rsp_valid <= 1'b1;
                        rsp_rdata <= '0;
                        rsp_err   <= (M_BRESP != 2'b00);
                    end
                end

                ST_RD_REQ: begin
                    if (M_ARREADY) begin
                        r_state   <= ST_RD_RESP;
                        M_ARVALID <= 1'b0;
                        M_RREADY  <= 1'b1;
                    end
                end

                ST_RD_RESP: begin
                    if (M_RVALID) begin
                        r_state   <= ST_RSP;
                        M_RREADY  <= 1'b0;
                        rsp_valid <= 1'b1;
                        rsp_rdata <= M_RDATA;
                        rsp_err   <= (M_RRESP != 2'b00);
                    end
                end

                ST_RSP: begin
                    if (rsp_ready) begin
                        r_state   <= ST_IDLE;
                        rsp_valid <= 1'b0;
                        req_ready <= 1'b1;
                    end
                end

                default: begin
                    r_state   <= ST_IDLE;
                    req_ready <= 1'b1;
                end
            endcase
        end
    end

endmodule
`default_nettype wire
